// File: rtl/id_ex_skid.sv
// ID-to-EX pipeline register with a one-entry skid buffer.
// Registered ready/valid on both sides, flush on redirect, stall counter.
module id_ex_skid #(
   parameter int             W       = 128,
   parameter logic [W-1:0]   NOP_VAL = '0,
   parameter int             CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [W-1:0]     in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [W-1:0]     out_data,
   input  logic             out_ready,
   output logic [1:0]       count,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     main_q, main_d;
   logic [W-1:0]     skid_q, skid_d;
   logic [CNT_W-1:0] stall_q;
   logic             push, pop;

   // Handshake outputs come straight from the state register.
   assign out_valid = (state_q != EMPTY);
   assign in_ready  = (state_q != FULL);
   assign out_data  = out_valid ? main_q : NOP_VAL;
   assign count     = state_q;
   assign stall_cnt = stall_q;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         main_q  <= NOP_VAL;
         skid_q  <= NOP_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = NOP_VAL;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (push) begin
                  main_d  = in_data;
                  state_d = ONE;
               end
            end
            ONE: begin
               case ({push, pop})
                  2'b11: main_d = in_data;
                  2'b10: begin
                     skid_d  = in_data;
                     state_d = FULL;
                  end
                  2'b01: begin
                     main_d  = NOP_VAL;
                     state_d = EMPTY;
                  end
                  default: ;
               endcase
            end
            FULL: begin
               if (pop) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = NOP_VAL;
            end
         endcase
      end
   end

   // Back-pressure counter survives flush; only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && stall_q != '1) begin
         stall_q <= stall_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_ex_skid.sv
// Bench for id_ex_skid: directed scenarios plus random traffic,
// checked against a queue-based model of the stage.
module tb_id_ex_skid;

   localparam int           W   = 32;
   localparam logic [W-1:0] NOP = 32'h0000_0013;

   logic         clk = 1'b0;
   logic         rst, flush, in_valid, out_ready;
   logic [W-1:0] in_data;

   logic         in_ready, out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   count;
   logic [15:0]  stall_cnt;

   logic         in_ready_s, out_valid_s;
   logic [W-1:0] out_data_s;
   logic [1:0]   count_s;
   logic [1:0]   stall_cnt_s;

   logic [W-1:0] q[$];
   int unsigned  stall;
   int           vecs = 0;
   int           errs = 0;

   always #5 clk = ~clk;

   id_ex_skid #(.W(W), .NOP_VAL(NOP), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .count(count), .stall_cnt(stall_cnt)
   );

   id_ex_skid #(.W(W), .NOP_VAL(NOP), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s),
      .out_valid(out_valid_s), .out_data(out_data_s), .out_ready(out_ready),
      .count(count_s), .stall_cnt(stall_cnt_s)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [W-1:0] exp_d;
      int unsigned  exp_s;
      exp_d = (q.size() != 0) ? q[0] : NOP;
      exp_s = (stall > 3) ? 3 : stall;
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() != 2));
      chk("count", 32'(count), 32'(q.size()));
      chk("out_data", out_data, exp_d);
      chk("stall_cnt", 32'(stall_cnt), stall & 32'hffff);
      chk("out_data_s", out_data_s, exp_d);
      chk("stall_cnt_s", 32'(stall_cnt_s), exp_s);
   endtask

   task automatic cyc(input logic fl, input logic iv,
                      input logic [W-1:0] d, input logic ordy);
      bit psh, pp;
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(posedge clk);
      psh = iv && (q.size() < 2);
      pp  = (q.size() > 0) && ordy;
      if (q.size() > 0 && !ordy) stall++;
      if (fl) begin
         q.delete();
      end else begin
         if (pp) void'(q.pop_front());
         if (psh) q.push_back(d);
      end
      @(negedge clk);
      check_all();
   endtask

   initial begin
      rst       = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      stall     = 0;
      @(negedge clk);
      check_all();
      rst = 1'b1;

      // Flow-through
      cyc(0, 1, 32'hA, 1);
      cyc(0, 1, 32'hB, 1);
      cyc(0, 1, 32'hC, 1);
      cyc(0, 0, 32'h0, 1);

      // Back-pressure fill, rejected third offer, held cycle
      cyc(0, 1, 32'hA, 0);
      cyc(0, 1, 32'hB, 0);
      cyc(0, 1, 32'hC, 0);
      cyc(0, 0, 32'h0, 0);

      // Drain
      cyc(0, 0, 32'h0, 1);
      cyc(0, 0, 32'h0, 1);

      // Flush collision from FULL
      cyc(0, 1, 32'h1A, 0);
      cyc(0, 1, 32'h1B, 0);
      cyc(1, 1, 32'h1C, 1);
      cyc(0, 0, 32'h0, 1);

      // Long hold to drive the narrow counter into saturation
      cyc(0, 1, 32'h55, 0);
      for (int i = 0; i < 6; i++) cyc(0, 0, 32'h0, 0);
      cyc(0, 0, 32'h0, 1);

      // Asynchronous reset while FULL
      cyc(0, 1, 32'h2A, 0);
      cyc(0, 1, 32'h2B, 0);
      #2 rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_data", out_data, NOP);
      chk("rst_stall", 32'(stall_cnt), 32'd0);
      chk("rst_stall_s", 32'(stall_cnt_s), 32'd0);
      q.delete();
      stall = 0;
      @(negedge clk);
      rst = 1'b1;
      check_all();
      cyc(0, 1, 32'hD, 1);
      chk("d_after_rst", out_data, 32'hD);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(0, 15) == 0,
             $urandom_range(0, 3) != 0,
             $urandom,
             $urandom_range(0, 2) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
